// File: rtl/wb_select_decoder.sv
// Writeback-select decoder: expands the 3-bit writeback code, forms the writeback value
// and issues one registered register-file write per retiring instruction.
module wb_select_decoder #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      wb_sel,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            flush,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [4:0]      sel_onehot,
    output logic            err,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StWaitLoad, StWrite} state_e;

    localparam logic [7:0] TimeoutLimit = 8'(LOAD_TIMEOUT);

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [7:0]      cnt_next;
    logic            accept;
    logic [4:0]      dec_onehot;
    logic [XLEN-1:0] dec_data;
    logic            dec_legal;
    logic            dec_load;

    assign in_ready = !flush && (state_q == StIdle || state_q == StWrite);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != StIdle);
    assign cnt_next = cnt_q + 8'd1;

    always_comb begin
        dec_onehot = '0;
        dec_data   = '0;
        dec_legal  = 1'b1;
        dec_load   = 1'b0;
        case (wb_sel)
            3'b000: begin
                dec_onehot = 5'b00001;
                dec_data   = alu_result;
            end
            3'b001: begin
                dec_onehot = 5'b00010;
                dec_load   = 1'b1;
            end
            3'b010: begin
                dec_onehot = 5'b00100;
                dec_data   = pc + XLEN'(4);
            end
            3'b011: begin
                dec_onehot = 5'b01000;
                dec_data   = pc + imm;
            end
            3'b100: begin
                dec_onehot = 5'b10000;
                dec_data   = imm;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            sel_onehot <= '0;
            err        <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            err   <= 1'b0;
            if (flush) begin
                // Flush drops any held instruction, including a load whose data arrives now.
                state_q <= StIdle;
            end else if (accept) begin
                rf_waddr   <= rd;
                rf_wdata   <= dec_data;
                sel_onehot <= dec_onehot;
                cnt_q      <= '0;
                if (!dec_legal) begin
                    err     <= 1'b1;
                    state_q <= StIdle;
                end else if (dec_load) begin
                    state_q <= StWaitLoad;
                end else begin
                    state_q <= StWrite;
                    rf_we   <= (rd != 5'd0);
                end
            end else begin
                case (state_q)
                    StWaitLoad: begin
                        if (load_valid) begin
                            rf_wdata <= load_data;
                            state_q  <= StWrite;
                            rf_we    <= (rf_waddr != 5'd0);
                        end else if (cnt_next == TimeoutLimit) begin
                            err     <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_next;
                        end
                    end
                    StWrite: state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_select_decoder.sv
// Directed bench for wb_select_decoder with LOAD_TIMEOUT=4 and hand-computed expectations.
module tb_wb_select_decoder;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      wb_sel;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            flush;
    logic            load_valid;
    logic [XLEN-1:0] load_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      sel_onehot;
    logic            err;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    wb_select_decoder #(
        .XLEN        (XLEN),
        .LOAD_TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wb_sel    (wb_sel),
        .rd        (rd),
        .alu_result(alu_result),
        .pc        (pc),
        .imm       (imm),
        .flush     (flush),
        .load_valid(load_valid),
        .load_data (load_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .sel_onehot(sel_onehot),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        wb_sel     = 3'd0;
        rd         = 5'd0;
        alu_result = '0;
        pc         = '0;
        imm        = '0;
        flush      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        step();
        step();
        rst = 1'b0;

        check_eq("reset rf_we", 64'(rf_we), 64'd0);
        check_eq("reset rf_waddr", 64'(rf_waddr), 64'd0);
        check_eq("reset rf_wdata", 64'(rf_wdata), 64'd0);
        check_eq("reset sel_onehot", 64'(sel_onehot), 64'd0);
        check_eq("reset err", 64'(err), 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd1);

        // ALU path
        in_valid   = 1'b1;
        wb_sel     = 3'b000;
        rd         = 5'd5;
        alu_result = 32'h0000_1234;
        step();
        in_valid = 1'b0;
        check_eq("alu rf_we", 64'(rf_we), 64'd1);
        check_eq("alu rf_waddr", 64'(rf_waddr), 64'd5);
        check_eq("alu rf_wdata", 64'(rf_wdata), 64'h1234);
        check_eq("alu sel_onehot", 64'(sel_onehot), 64'b00001);
        check_eq("alu busy", 64'(busy), 64'd1);
        step();
        check_eq("alu rf_we drop", 64'(rf_we), 64'd0);
        check_eq("alu idle", 64'(busy), 64'd0);

        // PC+4 then PC+IMM back to back
        in_valid = 1'b1;
        wb_sel   = 3'b010;
        rd       = 5'd1;
        pc       = 32'hFFFF_FFFC;
        check_eq("pc4 in_ready", 64'(in_ready), 64'd1);
        step();
        check_eq("pc4 rf_we", 64'(rf_we), 64'd1);
        check_eq("pc4 wrap rf_wdata", 64'(rf_wdata), 64'h0);
        check_eq("pc4 sel_onehot", 64'(sel_onehot), 64'b00100);
        wb_sel = 3'b011;
        rd     = 5'd2;
        pc     = 32'h0000_0100;
        imm    = 32'hFFFF_FFF0;
        check_eq("pcimm in_ready in write", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check_eq("pcimm rf_we", 64'(rf_we), 64'd1);
        check_eq("pcimm rf_wdata", 64'(rf_wdata), 64'hF0);
        check_eq("pcimm rf_waddr", 64'(rf_waddr), 64'd2);
        check_eq("pcimm sel_onehot", 64'(sel_onehot), 64'b01000);
        step();
        check_eq("pcimm rf_we drop", 64'(rf_we), 64'd0);

        // load_valid while idle is ignored
        load_valid = 1'b1;
        load_data  = 32'hCAFE_F00D;
        step();
        load_valid = 1'b0;
        check_eq("stray load busy", 64'(busy), 64'd0);
        check_eq("stray load rf_we", 64'(rf_we), 64'd0);

        // Load with data on the 3rd wait cycle; a stalled in_valid must not be captured
        in_valid = 1'b1;
        wb_sel   = 3'b001;
        rd       = 5'd7;
        step();
        in_valid = 1'b0;
        check_eq("load busy", 64'(busy), 64'd1);
        check_eq("load in_ready", 64'(in_ready), 64'd0);
        check_eq("load sel_onehot", 64'(sel_onehot), 64'b00010);
        check_eq("load rf_we wait1", 64'(rf_we), 64'd0);
        in_valid = 1'b1;
        wb_sel   = 3'b000;
        rd       = 5'd9;
        step();
        check_eq("load in_ready wait2", 64'(in_ready), 64'd0);
        check_eq("load rf_we wait2", 64'(rf_we), 64'd0);
        step();
        in_valid   = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        step();
        load_valid = 1'b0;
        check_eq("load rf_we", 64'(rf_we), 64'd1);
        check_eq("load rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        check_eq("load rf_waddr", 64'(rf_waddr), 64'd7);
        step();
        check_eq("load rf_we drop", 64'(rf_we), 64'd0);
        check_eq("load idle", 64'(busy), 64'd0);

        // Load timeout after 4 wait cycles
        in_valid = 1'b1;
        wb_sel   = 3'b001;
        rd       = 5'd3;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq($sformatf("timeout err early %0d", i), 64'(err), 64'd0);
            check_eq($sformatf("timeout busy %0d", i), 64'(busy), 64'd1);
            check_eq($sformatf("timeout rf_we %0d", i), 64'(rf_we), 64'd0);
        end
        step();
        check_eq("timeout err", 64'(err), 64'd1);
        check_eq("timeout rf_we", 64'(rf_we), 64'd0);
        check_eq("timeout idle", 64'(busy), 64'd0);
        step();
        check_eq("timeout err drop", 64'(err), 64'd0);

        // Illegal code
        in_valid = 1'b1;
        wb_sel   = 3'b110;
        rd       = 5'd4;
        step();
        in_valid = 1'b0;
        check_eq("illegal err", 64'(err), 64'd1);
        check_eq("illegal sel_onehot", 64'(sel_onehot), 64'd0);
        check_eq("illegal rf_we", 64'(rf_we), 64'd0);
        check_eq("illegal busy", 64'(busy), 64'd0);
        step();
        check_eq("illegal err drop", 64'(err), 64'd0);

        // IMM to x0: no write, data still updates
        in_valid = 1'b1;
        wb_sel   = 3'b100;
        rd       = 5'd0;
        imm      = 32'h0000_0055;
        step();
        in_valid = 1'b0;
        check_eq("x0 rf_we", 64'(rf_we), 64'd0);
        check_eq("x0 rf_wdata", 64'(rf_wdata), 64'h55);
        check_eq("x0 sel_onehot", 64'(sel_onehot), 64'b10000);
        step();

        // Flush during WAIT_LOAD coincident with load_valid
        in_valid = 1'b1;
        wb_sel   = 3'b001;
        rd       = 5'd7;
        step();
        in_valid   = 1'b0;
        flush      = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h1111_1111;
        check_eq("flush in_ready", 64'(in_ready), 64'd0);
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        check_eq("flush busy", 64'(busy), 64'd0);
        check_eq("flush rf_we", 64'(rf_we), 64'd0);
        check_eq("flush err", 64'(err), 64'd0);
        step();
        check_eq("flush rf_we later", 64'(rf_we), 64'd0);

        // Reset during WAIT_LOAD
        in_valid = 1'b1;
        wb_sel   = 3'b001;
        rd       = 5'd8;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst in_ready", 64'(in_ready), 64'd1);
        check_eq("rst rf_we", 64'(rf_we), 64'd0);
        check_eq("rst rf_waddr", 64'(rf_waddr), 64'd0);
        check_eq("rst rf_wdata", 64'(rf_wdata), 64'd0);
        check_eq("rst sel_onehot", 64'(sel_onehot), 64'd0);
        check_eq("rst err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
